// File: rtl/seq_lock_pkg.sv
// Shared types and counter-width helpers for the sequence lock controller.
package seq_lock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   localparam int DEF_SEQUENCE_WIDTH  = 3;
   localparam int DEF_COUNT_FOR_VALID = 2;
   localparam int DEF_LOSS_COUNT      = 2;
   localparam int DEF_TIMEOUT_CYCLES  = 16;

   // A run counter saturates at its limit, so it must be able to hold the limit itself.
   function automatic int run_cnt_w(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

   // The SEARCH timer only ever needs to reach cycles-1.
   function automatic int timer_cnt_w(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

   localparam int HIT_CNT_W   = run_cnt_w(DEF_COUNT_FOR_VALID);
   localparam int MISS_CNT_W  = run_cnt_w(DEF_LOSS_COUNT);
   localparam int TIMER_CNT_W = timer_cnt_w(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/seq_run_counter.sv
// Saturating consecutive-event counter; flags the event that completes a run of LIMIT.
module seq_run_counter
   import seq_lock_pkg::*;
#(
   parameter int LIMIT = 2
)(
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_hit_at_limit
);

   localparam int CNT_W = run_cnt_w(LIMIT);

   logic [CNT_W-1:0] r_count;

   // Run length register: clear dominates, increments stop at LIMIT.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_count <= {CNT_W{1'b0}};
      end else if (i_clr) begin
         r_count <= {CNT_W{1'b0}};
      end else if (i_inc && (r_count != CNT_W'(LIMIT))) begin
         r_count <= r_count + CNT_W'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign o_hit_at_limit = i_inc && !i_clr && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/sequence_lock_controller.sv
// Pattern-lock acquisition FSM (IDLE/SEARCH/LOCKED) with registered status outputs.
// Define LOCK_TIMEOUT_EN to build the SEARCH timeout timer and timeout_flag.
module sequence_lock_controller
   import seq_lock_pkg::*;
#(
   parameter int SEQUENCE_WIDTH  = DEF_SEQUENCE_WIDTH,
   parameter int COUNT_FOR_VALID = DEF_COUNT_FOR_VALID,
   parameter int LOSS_COUNT      = DEF_LOSS_COUNT
`ifdef LOCK_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
)(
   input  logic                      i_clk,
   input  logic                      i_resetn,
   input  logic                      i_start,
   input  logic                      i_abort,
   input  logic [SEQUENCE_WIDTH-1:0] i_pattern,
   input  logic [SEQUENCE_WIDTH-1:0] i_sequence,
   input  logic                      i_seq_valid,
   output logic                      o_busy,
   output logic                      o_locked,
   output logic                      o_lock_lost,
   output logic                      o_done,
   output logic                      o_timeout_flag
);

   state_e                    r_state;
   state_e                    w_state_nxt;
   logic [SEQUENCE_WIDTH-1:0] r_pattern;
   logic w_match, w_start_acc, w_lock, w_lost, w_timeout;
   logic w_hit_clr, w_hit_inc, w_miss_clr, w_miss_inc;
   logic w_timeout_nxt;
   logic r_busy, r_locked, r_lock_lost, r_done, r_timeout_flag;

   assign w_match     = (i_sequence == r_pattern);
   assign w_start_acc = (r_state == ST_IDLE) && i_start && !i_abort;

   assign w_hit_inc  = (r_state == ST_SEARCH) && i_seq_valid && w_match;
   assign w_hit_clr  = w_start_acc || w_lost ||
                       ((r_state == ST_SEARCH) && i_seq_valid && !w_match);
   assign w_miss_inc = (r_state == ST_LOCKED) && i_seq_valid && !w_match;
   assign w_miss_clr = w_start_acc || w_lock ||
                       ((r_state == ST_LOCKED) && i_seq_valid && w_match);

   seq_run_counter #(.LIMIT(COUNT_FOR_VALID)) u_hit_cnt (
      .i_clk          (i_clk),
      .i_resetn       (i_resetn),
      .i_clr          (w_hit_clr),
      .i_inc          (w_hit_inc),
      .o_hit_at_limit (w_lock)
   );

   seq_run_counter #(.LIMIT(LOSS_COUNT)) u_miss_cnt (
      .i_clk          (i_clk),
      .i_resetn       (i_resetn),
      .i_clr          (w_miss_clr),
      .i_inc          (w_miss_inc),
      .o_hit_at_limit (w_lost)
   );

`ifdef LOCK_TIMEOUT_EN
   localparam int TIMER_W = timer_cnt_w(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [TIMER_W-1:0] r_timer;

   // SEARCH timer: restarts on every entry into SEARCH, counts every clock while searching.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_timer <= {TIMER_W{1'b0}};
      end else if (w_start_acc || w_lost) begin
         r_timer <= {TIMER_W{1'b0}};
      end else if ((r_state == ST_SEARCH) && (r_timer != TIMER_LAST)) begin
         r_timer <= r_timer + TIMER_W'(1);
      end else begin
         r_timer <= r_timer;
      end
   end

   assign w_timeout = (r_state == ST_SEARCH) && (r_timer == TIMER_LAST) && !w_lock;
`else
   assign w_timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: abort beats lock, and lock beats timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_acc) begin
               w_state_nxt = ST_SEARCH;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SEARCH: begin
            if (i_abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_lock) begin
               w_state_nxt = ST_LOCKED;
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_SEARCH;
            end
         end
         ST_LOCKED: begin
            if (i_abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_lost) begin
               w_state_nxt = ST_SEARCH;
            end else begin
               w_state_nxt = ST_LOCKED;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Sticky timeout flag: a fresh start clears it, abort leaves it alone.
   always_comb begin
      w_timeout_nxt = r_timeout_flag;
      if (w_start_acc) begin
         w_timeout_nxt = 1'b0;
      end else if (w_timeout && !i_abort) begin
         w_timeout_nxt = 1'b1;
      end else begin
         w_timeout_nxt = r_timeout_flag;
      end
   end

   // Pattern latch and registered status outputs derived from the next state.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_pattern      <= {SEQUENCE_WIDTH{1'b0}};
         r_busy         <= 1'b0;
         r_locked       <= 1'b0;
         r_lock_lost    <= 1'b0;
         r_done         <= 1'b0;
         r_timeout_flag <= 1'b0;
      end else begin
         r_pattern      <= w_start_acc ? i_pattern : r_pattern;
         r_busy         <= (w_state_nxt != ST_IDLE);
         r_locked       <= (w_state_nxt == ST_LOCKED);
         r_lock_lost    <= (r_state == ST_LOCKED) && (w_state_nxt == ST_SEARCH);
         r_done         <= (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
         r_timeout_flag <= w_timeout_nxt;
      end
   end

   assign o_busy         = r_busy;
   assign o_locked       = r_locked;
   assign o_lock_lost    = r_lock_lost;
   assign o_done         = r_done;
   assign o_timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_sequence_lock_controller.sv
// Directed bench for sequence_lock_controller; outputs checked as {busy,locked,lock_lost,done,timeout_flag}.
module tb_sequence_lock_controller;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start, abort, seq_valid;
   logic [2:0] pattern, seq;
   logic       busy, locked, lock_lost, done, timeout_flag;

   int vectors     = 0;
   int miscompares = 0;

   sequence_lock_controller dut (
      .i_clk          (clk),
      .i_resetn       (resetn),
      .i_start        (start),
      .i_abort        (abort),
      .i_pattern      (pattern),
      .i_sequence     (seq),
      .i_seq_valid    (seq_valid),
      .o_busy         (busy),
      .o_locked       (locked),
      .o_lock_lost    (lock_lost),
      .o_done         (done),
      .o_timeout_flag (timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [4:0] exp);
      logic [4:0] got;
      got = {busy, locked, lock_lost, done, timeout_flag};
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic a, input logic v, input logic [2:0] sq);
      start = s; abort = a; seq_valid = v; seq = sq;
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0; seq_valid = 1'b0; seq = 3'b000;
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; abort = 1'b0; seq_valid = 1'b0;
      pattern = 3'b000; seq = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 5'b00000);
      resetn = 1'b1;

      // basic lock; pattern input changes after start to prove it is latched
      pattern = 3'b101;
      cyc(1'b1, 1'b0, 1'b0, 3'b000); chk("start_busy", 5'b10000);
      pattern = 3'b000;
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("match1", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("lock", 5'b11000);

      // loss after two misses
      cyc(1'b0, 1'b0, 1'b1, 3'b000); chk("miss1", 5'b11000);
      cyc(1'b0, 1'b0, 1'b1, 3'b000); chk("lost", 5'b10100);
      cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("lost_pulse_end", 5'b10000);

      // broken run with valid gaps
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("run_a1", 5'b10000);
      cyc(1'b0, 1'b0, 1'b0, 3'b111); chk("gap1", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b011); chk("run_break", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("run_b1", 5'b10000);
      cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("gap2", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("relock", 5'b11000);

      // start while busy must not reload the pattern
      pattern = 3'b011;
      cyc(1'b1, 1'b0, 1'b1, 3'b101); chk("start_ignored", 5'b11000);
      cyc(1'b0, 1'b0, 1'b1, 3'b011); chk("old_pat_miss1", 5'b11000);
      cyc(1'b0, 1'b0, 1'b1, 3'b011); chk("old_pat_lost", 5'b10100);
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("relock_m1", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("relock2", 5'b11000);

      // abort from LOCKED, then start+abort in IDLE
      cyc(1'b0, 1'b1, 1'b0, 3'b000); chk("abort_done", 5'b00010);
      cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("abort_idle", 5'b00000);
      cyc(1'b1, 1'b1, 1'b0, 3'b000); chk("start_abort", 5'b00000);
      cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("start_abort_idle", 5'b00000);

`ifdef LOCK_TIMEOUT_EN
      pattern = 3'b111;
      cyc(1'b1, 1'b0, 1'b0, 3'b000); chk("to_start", 5'b10000);
      for (int i = 1; i <= 15; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("to_search", 5'b10000);
      end
      cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("timeout", 5'b00011);
      cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("timeout_sticky", 5'b00001);
      cyc(1'b1, 1'b0, 1'b0, 3'b000); chk("start_clears_to", 5'b10000);
      for (int i = 1; i <= 14; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 3'b000);
      end
      chk("edge14", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b111); chk("edge15_match", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b111); chk("edge16_lock", 5'b11000);
      cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("edge16_stay", 5'b11000);
      cyc(1'b0, 1'b1, 1'b0, 3'b000); chk("to_abort", 5'b00010);
`else
      pattern = 3'b111;
      cyc(1'b1, 1'b0, 1'b0, 3'b000); chk("nto_start", 5'b10000);
      for (int i = 1; i <= 20; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("nto_search", 5'b10000);
      end
      cyc(1'b0, 1'b1, 1'b0, 3'b000); chk("nto_abort", 5'b00010);
`endif
      cyc(1'b0, 1'b0, 1'b0, 3'b000); chk("idle_again", 5'b00000);

      // asynchronous reset in the middle of SEARCH
      pattern = 3'b101;
      cyc(1'b1, 1'b0, 1'b0, 3'b000); chk("rst_start", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("rst_m1", 5'b10000);
      resetn = 1'b0;
      #1;
      chk("rst_async", 5'b00000);
      @(posedge clk);
      #1;
      chk("rst_held", 5'b00000);
      resetn = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("rst_no_done", 5'b00000);
      cyc(1'b1, 1'b0, 1'b0, 3'b000); chk("post_rst_start", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("post_rst_m1", 5'b10000);
      cyc(1'b0, 1'b0, 1'b1, 3'b101); chk("post_rst_lock", 5'b11000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sequence_lock_controller.md
# sequence_lock_controller

Controller that sequences pattern-lock acquisition on the serial protocol sequence stream. It owns the qualifier timing and decides search, lock and loss from a programmable target pattern. It requires a programmable number of consecutive matches to lock, and a programmable number of consecutive misses to declare loss. It sits between the link front end, which supplies `sequence`/`seq_valid`, and the host, which issues `start`/`abort` and reads status.

## Interface
- `SEQUENCE_WIDTH`, 3, width of one sequence sample and of the pattern.
- `COUNT_FOR_VALID`, 2, consecutive matching samples required to lock; ≥1.
- `LOSS_COUNT`, 2, consecutive mismatching samples in LOCKED that declare loss; ≥1.
- `TIMEOUT_CYCLES`, 16, clock cycles allowed in SEARCH before giving up; ≥2.
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin acquisition; honoured only in IDLE.
- `abort`  in  1  return to IDLE from any state; highest priority.
- `pattern`  in  SEQUENCE_WIDTH  target pattern, latched on an accepted `start`.
- `sequence`  in  SEQUENCE_WIDTH  incoming sample.
- `seq_valid`  in  1  `sequence` is meaningful this cycle; samples with `seq_valid`=0 are ignored.
- `busy`  out  1  state ≠ IDLE.
- `locked`  out  1  state = LOCKED.
- `lock_lost`  out  1  one-cycle pulse on LOCKED→SEARCH.
- `done`  out  1  one-cycle pulse on any return to IDLE from SEARCH/LOCKED.
- `timeout_flag`  out  1  sticky; set on timeout, cleared by next accepted `start`.

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE, and the latched pattern and all counters reset to 0.
- States: IDLE, SEARCH, LOCKED.
- IDLE: on `start`, latch `pattern`, clear hit, miss and timer counts, clear `timeout_flag`, and go to SEARCH.
- SEARCH, per `seq_valid` sample:
  - A match is `sequence`==latched pattern. A match increments hit_cnt; a mismatch clears it.
  - When a match arrives with hit_cnt==COUNT_FOR_VALID-1, go to LOCKED and clear miss_cnt.
- SEARCH timer: counts every clock (regardless of `seq_valid`).
  - If timer==TIMEOUT_CYCLES-1 and no lock occurs on that edge, go to IDLE, pulse `done`, and set `timeout_flag`.
  - Lock and timeout on the same edge: lock wins.
- LOCKED, per `seq_valid` sample:
  - A mismatch increments miss_cnt; a match clears it.
  - When a mismatch arrives with miss_cnt==LOSS_COUNT-1, go to SEARCH, pulse `lock_lost`, and clear hit_cnt and the timer.
- `abort` (any non-IDLE state): go to IDLE next edge and pulse `done`. `timeout_flag` is unchanged. `abort` in IDLE has no effect. `abort` and `start` together in IDLE: `abort` wins, and `start` is dropped.
- `start` while busy is ignored; the latched pattern is not updated.
- Counters saturate and never wrap. hit_cnt width is $clog2(COUNT_FOR_VALID+1). The timer width is $clog2(TIMEOUT_CYCLES).
- Reset mid-operation: immediate return to IDLE with all outputs 0. No `done` pulse is generated.

## Timing
- `start` sampled at edge 0: `busy`=1 after edge 0.
- Lock latency is zero extra cycles. With COUNT_FOR_VALID=2 and matching samples at edges 1 and 2, `locked`=1 after edge 2.
- SEARCH lasts at most exactly TIMEOUT_CYCLES edges. `done` and `timeout_flag` rise after the last edge, in the same cycle that `busy` falls.
- `lock_lost` rises together with the fall of `locked`.
- `done` follows `abort` by one edge.

## Configuration
- `LOCK_TIMEOUT_EN` defined: the timer exists and the timeout behaviour is as above.
- `LOCK_TIMEOUT_EN` undefined:
  - No timer logic is present, and SEARCH persists until lock or `abort`.
  - `timeout_flag` is tied to 0, and `TIMEOUT_CYCLES` is unused.

## Structure
- The shared package `seq_lock_pkg` holds:
  - the state enum (IDLE, SEARCH, LOCKED);
  - the localparam widths for the hit, miss and timer counters.
- Sub-module `seq_run_counter` is a saturating consecutive-event counter with `clr`, `inc` and a `hit_at_limit` output. It is instantiated twice: once for hits, once for misses.
- The FSM, timer and output registers live in the top.

## Test plan
- Default params, pattern 3'b101, `start`, then samples 101, 101 with `seq_valid`=1 → `locked`=1 after the 2nd sample edge, `busy`=1.
- Samples 101, 011, 101, 101 → no lock after sample 2; lock after sample 4. `seq_valid`=0 gaps between samples do not break the run.
- Locked; samples 000, 000 → `lock_lost` one-cycle pulse and `locked`=0 after the 2nd mismatch; state is SEARCH with the timer restarted.
- `LOCK_TIMEOUT_EN`, TIMEOUT_CYCLES=16, no matches → after exactly 16 edges: `done` pulse, `timeout_flag`=1, `busy`=0. The next `start` clears `timeout_flag`.
- Lock-completing match on the 16th SEARCH edge → `locked`=1, no timeout, no `done`.
- `abort` in LOCKED → `done` pulse next edge and `locked`=0. `start`+`abort` in IDLE → stays IDLE. `resetn` low mid-SEARCH → all outputs 0 immediately.
